wb_master_port: RTL
===================

Name: wb_master_port

Overview:
- Wishbone classic single-cycle initiator. Converts request/response handshakes from an internal engine (DMA, debug bridge, test sequencer) into Wishbone read/write cycles toward peripheral slave ports on the same bus (SPI master, UART).
- Terminates every cycle on ack, err, retry exhaustion or timeout.
- Returns read data and a status code to the engine.

Parameters:
ADR_W, 8, Wishbone address width
DAT_W, 32, data width; sel width is DAT_W/8
TIMEOUT, 255, max BUS-state cycles before abort; 0 disables timeout
MAX_RETRY, 3, reissues allowed after wbm_rty_i
RTY_GAP, 2, idle cycles (cyc low) between a retry and its reissue; minimum 1

Ports:
clk  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1=write, 0=read
req_adr_i  in  ADR_W  target address
req_dat_i  in  DAT_W  write data
req_sel_i  in  DAT_W/8  byte selects
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_dat_o  out  DAT_W  read data; 0 for writes and failures
rsp_sts_o  out  2  0=OK, 1=ERR, 2=TIMEOUT, 3=RETRY_EXHAUSTED
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_we_o  out  1  write enable
wbm_adr_o  out  ADR_W  address
wbm_dat_o  out  DAT_W  write data
wbm_sel_o  out  DAT_W/8  byte selects
wbm_cti_o  out  3  constant 3'b000, classic cycle
wbm_bte_o  out  2  constant 2'b00
wbm_dat_i  in  DAT_W  read data
wbm_ack_i  in  1  acknowledge
wbm_err_i  in  1  error
wbm_rty_i  in  1  retry

Behaviour:
- All outputs are registered except req_ready_o, which decodes state==IDLE.
- Reset values: all registered outputs 0, state IDLE, retry and timer counters 0.
- States: IDLE, BUS, GAP, RESP.
- IDLE:
  - req_ready_o=1.
  - On valid&ready at edge N: latch we/adr/dat/sel, clear retry_cnt and timer, go to BUS.
  - wbm_cyc_o and wbm_stb_o are high from cycle N+1.
- BUS:
  - cyc, stb, we, adr, dat and sel are held stable. Timer increments each cycle.
  - Terminations are sampled at each edge with priority err > ack > rty > timeout.
  - ack: rsp_dat_o <= wbm_dat_i for reads, 0 for writes; sts=OK; go to RESP.
  - err: sts=ERR; go to RESP.
  - rty with retry_cnt<MAX_RETRY: retry_cnt++, go to GAP.
  - rty with retry_cnt==MAX_RETRY: sts=RETRY_EXHAUSTED; go to RESP.
  - Timeout (TIMEOUT!=0, timer==TIMEOUT-1, no termination this edge): sts=TIMEOUT; go to RESP.
  - Every exit from BUS drops cyc and stb on the same edge. The bus never sees stb high past the terminating edge.
- GAP:
  - cyc=stb=0 for exactly RTY_GAP cycles, then return to BUS with the same latched request.
  - Timer clears on each reissue.
- RESP:
  - rsp_valid_o=1, with rsp_dat_o and rsp_sts_o stable until rsp_valid&rsp_ready.
  - After that edge go to IDLE with rsp_valid_o=0. A new request can be accepted the following cycle.
- Latency: for a slave that acks K cycles after first seeing stb (K>=1), rsp_valid_o rises K+1 cycles after request acceptance.
- ack, err and rty outside BUS are ignored; spurious terminations cause no state change.
- req_ready_o=0 in BUS, GAP and RESP, so at most one transaction is outstanding.
- Reset mid-transaction: cyc and stb drop asynchronously and the pending transaction is discarded. No response is produced.

Test Plan:
- Write adr=0x10, dat=0xA5A5_0001, sel=4'hF; slave acks 2 cycles after stb -> one cyc/stb pulse 2 cycles long, we=1; rsp_sts=0, rsp_dat=0; rsp_valid rises 3 cycles after accept.
- Read adr=0x04; slave returns 0xDEAD_BEEF with ack -> rsp_dat=0xDEAD_BEEF, sts=0. Holding rsp_ready=0 for 5 cycles keeps rsp_valid/rsp_dat stable and req_ready=0.
- Slave asserts rty twice, then ack -> three stb pulses separated by exactly 2 low cycles, identical adr/dat each time; sts=0.
- Slave asserts rty on every attempt -> 4 stb pulses (1+MAX_RETRY); sts=3.
- No termination from slave -> stb high for exactly 255 cycles, then drops; sts=2. Same edge err+ack -> sts=1.
- Assert wb_rst_i while in BUS -> cyc/stb go 0 immediately, no rsp_valid. After release, a new request completes normally.

Source files
------------

// File: rtl/wb_master_port.sv
// Wishbone classic single-cycle initiator: turns engine request/response handshakes into
// bus cycles, terminating on ack, err, retry exhaustion or timeout.
module wb_master_port #(
    parameter int ADR_W     = 8,
    parameter int DAT_W     = 32,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3,
    parameter int RTY_GAP   = 2
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [ADR_W-1:0]   req_adr_i,
    input  logic [DAT_W-1:0]   req_dat_i,
    input  logic [DAT_W/8-1:0] req_sel_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DAT_W-1:0]   rsp_dat_o,
    output logic [1:0]         rsp_sts_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [DAT_W-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = (RTY_GAP > 1) ? $clog2(RTY_GAP) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RTY_GAP - 1);

    typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_e;
    typedef enum logic [1:0] {STS_OK, STS_ERR, STS_TIMEOUT, STS_RETRY_EXH} sts_e;

    state_e             state, state_d;
    logic [TMR_W-1:0]   timer, timer_d;
    logic [RTY_W-1:0]   retry_cnt, retry_cnt_d;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
    logic               cyc_d, we_d, rsp_valid_d;
    logic [ADR_W-1:0]   adr_d;
    logic [DAT_W-1:0]   dat_d, rsp_dat_d;
    logic [DAT_W/8-1:0] sel_d;
    logic [1:0]         rsp_sts_d;

    assign req_ready_o = (state == IDLE);
    assign wbm_cti_o   = 3'b000;
    assign wbm_bte_o   = 2'b00;

    // NOTE: combinational logic uses blocking '=' and assigns every output a default first,
    // so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state;
        timer_d     = timer;
        retry_cnt_d = retry_cnt;
        gap_cnt_d   = gap_cnt;
        cyc_d       = wbm_cyc_o;
        we_d        = wbm_we_o;
        adr_d       = wbm_adr_o;
        dat_d       = wbm_dat_o;
        sel_d       = wbm_sel_o;
        rsp_valid_d = rsp_valid_o;
        rsp_dat_d   = rsp_dat_o;
        rsp_sts_d   = rsp_sts_o;

        unique case (state)
            IDLE: if (req_valid_i) begin
                we_d        = req_we_i;
                adr_d       = req_adr_i;
                dat_d       = req_dat_i;
                sel_d       = req_sel_i;
                timer_d     = '0;
                retry_cnt_d = '0;
                cyc_d       = 1'b1;
                state_d     = BUS;
            end
            BUS: begin
                timer_d = timer + TMR_W'(1);
                // Any exit from BUS lowers cyc/stb on the terminating edge.
                if (wbm_err_i) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = '0;
                    rsp_sts_d = STS_ERR;
                    state_d   = RESP;
                end else if (wbm_ack_i) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = wbm_we_o ? '0 : wbm_dat_i;
                    rsp_sts_d = STS_OK;
                    state_d   = RESP;
                end else if (wbm_rty_i) begin
                    cyc_d = 1'b0;
                    if (retry_cnt == RTY_MAX) begin
                        rsp_dat_d = '0;
                        rsp_sts_d = STS_RETRY_EXH;
                        state_d   = RESP;
                    end else begin
                        retry_cnt_d = retry_cnt + RTY_W'(1);
                        gap_cnt_d   = '0;
                        state_d     = GAP;
                    end
                end else if (TIMEOUT != 0 && timer == TMR_LAST) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = '0;
                    rsp_sts_d = STS_TIMEOUT;
                    state_d   = RESP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    cyc_d   = 1'b1;
                    timer_d = '0;
                    state_d = BUS;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end
            end
            RESP: begin
                // valid rises one cycle after the bus cycle ends and falls on the handshake edge.
                if (!rsp_valid_o) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the asynchronous reset drops cyc/stb immediately and discards any pending transaction.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            timer       <= '0;
            retry_cnt   <= '0;
            gap_cnt     <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_sts_o   <= STS_OK;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            retry_cnt   <= retry_cnt_d;
            gap_cnt     <= gap_cnt_d;
            wbm_cyc_o   <= cyc_d;
            wbm_stb_o   <= cyc_d;
            wbm_we_o    <= we_d;
            wbm_adr_o   <= adr_d;
            wbm_dat_o   <= dat_d;
            wbm_sel_o   <= sel_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_dat_o   <= rsp_dat_d;
            rsp_sts_o   <= rsp_sts_d;
        end
    end

endmodule
